// File: rtl/ahb_master_traffic_gen.sv
// ---------------------------------------------------------------------------
// ahb_master_traffic_gen
//
// Programmable stimulus master for the request side of an AHB master
// interface. One accepted start runs a write-then-readback sweep over
// NUM_SLV slaves. For each slave it writes num_words words, then reads them
// back and compares each word with the pattern it wrote. Readback mismatches
// are counted with saturation. A transfer that sees no xfer_done within
// TIMEOUT cycles aborts the whole run.
//
// Data pattern : PATTERN + (slave << 8) + word_index
// Address      : BASE_ADDR + word_index * (DATA_W/8)
//
// Ports
//   hclk        in   clock
//   hreset      in   synchronous reset, active-high
//   start       in   one-cycle run request, honoured only when idle
//   num_words   in   words per slave, sampled on an accepted start
//   dout        in   read data from the master interface (valid with xfer_done)
//   xfer_done   in   one-cycle pulse, current transfer completed
//   addr        out  transfer address
//   slv_sel_in  out  slave select
//   din         out  write data
//   wr          out  1 = write, 0 = read
//   enable      out  transfer enable to the master interface
//   hbusreq_in  out  bus request
//   busy        out  run in progress
//   done        out  one-cycle pulse at the end of a run (normal or abort)
//   err_cnt     out  readback mismatches in the last run, saturating
//   timeout_err out  sticky, last run aborted on a transfer timeout
//
// Timing: every output is a register. Control outputs are loaded on the
// edge that enters a state, so enable is high for exactly the cycles spent
// in WR/RD. FIN is one cycle with busy still high and the bus released. On
// the edge leaving FIN, busy drops and done pulses for one cycle.
// ---------------------------------------------------------------------------
module ahb_master_traffic_gen #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_SLV   = 4,
  parameter int                LEN_W     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [DATA_W-1:0] PATTERN   = DATA_W'(32'hA5A5_0000),
  parameter int                TIMEOUT   = 64,
  parameter int                ERR_W     = 8,
  localparam int               SEL_W     = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              start,
  input  logic [LEN_W-1:0]  num_words,
  input  logic [DATA_W-1:0] dout,
  input  logic              xfer_done,
  output logic [ADDR_W-1:0] addr,
  output logic [SEL_W-1:0]  slv_sel_in,
  output logic [DATA_W-1:0] din,
  output logic              wr,
  output logic              enable,
  output logic              hbusreq_in,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              timeout_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WGAP,
    S_RD,
    S_RGAP,
    S_FIN
  } state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_nw;    // words per slave for this run
  logic [LEN_W-1:0] r_idx;   // word index within the current slave
  logic [SEL_W-1:0] r_slv;   // slave currently being swept
  logic [TMO_W-1:0] r_tmo;   // cycles already spent in the current WR/RD

  logic             w_last_idx;
  logic             w_last_slv;
  logic             w_tmo_hit;
  logic [LEN_W-1:0] w_idx_inc;
  logic [SEL_W-1:0] w_slv_inc;

  // Only used from WGAP/RGAP/RD, where r_nw is known to be non-zero.
  assign w_last_idx = (r_idx == r_nw - LEN_W'(1));
  assign w_last_slv = (r_slv == SEL_W'(NUM_SLV - 1));
  // True in the TIMEOUT-th cycle of a transfer. That cycle still accepts
  // xfer_done, which takes priority over the abort.
  assign w_tmo_hit  = (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_idx_inc  = r_idx + LEN_W'(1);
  assign w_slv_inc  = r_slv + SEL_W'(1);

  function automatic logic [ADDR_W-1:0] f_addr(input logic [LEN_W-1:0] idx);
    return BASE_ADDR + ADDR_W'(idx) * ADDR_W'(BYTES);
  endfunction

  function automatic logic [DATA_W-1:0] f_data(input logic [SEL_W-1:0] slv,
                                               input logic [LEN_W-1:0] idx);
    return PATTERN + (DATA_W'(slv) << 8) + DATA_W'(idx);
  endfunction

  // NOTE: every register here is written with <= so all right-hand sides
  // see the pre-edge values; mixing in = would make the result depend on
  // statement order.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state     <= S_IDLE;
      r_nw        <= '0;
      r_idx       <= '0;
      r_slv       <= '0;
      r_tmo       <= '0;
      addr        <= '0;
      slv_sel_in  <= '0;
      din         <= '0;
      wr          <= 1'b1;
      enable      <= 1'b0;
      hbusreq_in  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_nw        <= num_words;
            r_slv       <= '0;
            r_idx       <= '0;
            err_cnt     <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            if (num_words == '0) begin
              r_state <= S_FIN;
            end else begin
              r_state    <= S_WR;
              r_tmo      <= '0;
              addr       <= f_addr('0);
              din        <= f_data('0, '0);
              slv_sel_in <= '0;
              wr         <= 1'b1;
              enable     <= 1'b1;
              hbusreq_in <= 1'b1;
            end
          end
        end

        S_WR: begin
          if (xfer_done) begin
            r_state <= S_WGAP;
            enable  <= 1'b0;
          end else if (w_tmo_hit) begin
            r_state     <= S_FIN;
            timeout_err <= 1'b1;
            enable      <= 1'b0;
            hbusreq_in  <= 1'b0;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end

        S_WGAP: begin
          r_tmo  <= '0;
          enable <= 1'b1;
          if (!w_last_idx) begin
            r_idx   <= w_idx_inc;
            r_state <= S_WR;
            addr    <= f_addr(w_idx_inc);
            din     <= f_data(r_slv, w_idx_inc);
          end else begin
            r_idx   <= '0;
            r_state <= S_RD;
            addr    <= f_addr('0);
            wr      <= 1'b0;
          end
        end

        S_RD: begin
          if (xfer_done) begin
            if ((dout != f_data(r_slv, r_idx)) && (err_cnt != '1))
              err_cnt <= err_cnt + ERR_W'(1);
            r_state <= S_RGAP;
            enable  <= 1'b0;
            // Release the bus for the single gap cycle between slaves.
            if (w_last_idx && !w_last_slv)
              hbusreq_in <= 1'b0;
          end else if (w_tmo_hit) begin
            r_state     <= S_FIN;
            timeout_err <= 1'b1;
            enable      <= 1'b0;
            hbusreq_in  <= 1'b0;
            wr          <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end

        S_RGAP: begin
          if (!w_last_idx) begin
            r_idx   <= w_idx_inc;
            r_state <= S_RD;
            r_tmo   <= '0;
            addr    <= f_addr(w_idx_inc);
            enable  <= 1'b1;
          end else if (!w_last_slv) begin
            r_slv      <= w_slv_inc;
            r_idx      <= '0;
            r_state    <= S_WR;
            r_tmo      <= '0;
            addr       <= f_addr('0);
            din        <= f_data(w_slv_inc, '0);
            slv_sel_in <= w_slv_inc;
            wr         <= 1'b1;
            enable     <= 1'b1;
            hbusreq_in <= 1'b1;
          end else begin
            r_state    <= S_FIN;
            hbusreq_in <= 1'b0;
            wr         <= 1'b1;
          end
        end

        S_FIN: begin
          r_state    <= S_IDLE;
          busy       <= 1'b0;
          done       <= 1'b1;
          enable     <= 1'b0;
          hbusreq_in <= 1'b0;
          wr         <= 1'b1;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master_traffic_gen.sv
// ---------------------------------------------------------------------------
// Testbench for ahb_master_traffic_gen.
//
// The bench acts as the master interface. It watches enable, records each
// transfer, and answers after a programmed delay. Read requests are answered
// from a memory that holds what the DUT wrote. The answer can instead be
// forced to zero or have a bit flipped.
//
// The expected transfer sequence, mismatch count, busy/enable cycle counts
// and bus-request gaps are derived from the sweep rules. This derivation
// uses plain loops and arithmetic over the delays the responder actually
// used.
//
// A second instance with ERR_W=2 sees identical stimulus. It is used to
// check that the error counter saturates.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ahb_master_traffic_gen;

  localparam int          NUM_SLV = 4;
  localparam int          TIMEOUT = 64;
  localparam logic [31:0] PATTERN = 32'hA5A5_0000;
  localparam logic [31:0] BASE    = 32'h0;
  localparam int          BUDGET  = 3000;

  logic        hclk, hreset, start, xfer_done;
  logic [3:0]  num_words;
  logic [31:0] dout;
  logic [31:0] addr, din;
  logic [1:0]  slv_sel_in;
  logic        wr, enable, hbusreq_in, busy, done, timeout_err;
  logic [7:0]  err_cnt;

  logic [31:0] s_addr, s_din;
  logic [1:0]  s_slv_sel_in;
  logic        s_wr, s_enable, s_hbusreq_in, s_busy, s_done, s_timeout_err;
  logic [1:0]  s_err_cnt;

  ahb_master_traffic_gen u_dut (
    .hclk(hclk), .hreset(hreset), .start(start), .num_words(num_words),
    .dout(dout), .xfer_done(xfer_done), .addr(addr), .slv_sel_in(slv_sel_in),
    .din(din), .wr(wr), .enable(enable), .hbusreq_in(hbusreq_in),
    .busy(busy), .done(done), .err_cnt(err_cnt), .timeout_err(timeout_err)
  );

  ahb_master_traffic_gen #(.ERR_W(2)) u_sat (
    .hclk(hclk), .hreset(hreset), .start(start), .num_words(num_words),
    .dout(dout), .xfer_done(xfer_done), .addr(s_addr), .slv_sel_in(s_slv_sel_in),
    .din(s_din), .wr(s_wr), .enable(s_enable), .hbusreq_in(s_hbusreq_in),
    .busy(s_busy), .done(s_done), .err_cnt(s_err_cnt), .timeout_err(s_timeout_err)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Field order: nw, delay, first_delay, zero_mask, rnd_corrupt, restart,
  // spurious, exp_xfers, exp_err, exp_tmo. A delay of 0 means a random delay
  // of 1..5 cycles. A delay above TIMEOUT means the transfer is never answered.
  typedef struct {
    int         nw;
    int         delay;
    int         first_delay;
    logic [3:0] zero_mask;
    bit         rnd_corrupt;
    bit         restart;
    bit         spurious;
    int         exp_xfers;
    int         exp_err;
    bit         exp_tmo;
  } vec_t;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] din;
  } xfer_t;

  int   n_cmp;
  int   n_bad;
  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "/addr"},        64'(addr),        64'h0);
    check({tag, "/slv_sel_in"},  64'(slv_sel_in),  64'h0);
    check({tag, "/din"},         64'(din),         64'h0);
    check({tag, "/wr"},          64'(wr),          64'h1);
    check({tag, "/enable"},      64'(enable),      64'h0);
    check({tag, "/hbusreq_in"},  64'(hbusreq_in),  64'h0);
    check({tag, "/busy"},        64'(busy),        64'h0);
    check({tag, "/done"},        64'(done),        64'h0);
    check({tag, "/err_cnt"},     64'(err_cnt),     64'h0);
    check({tag, "/timeout_err"}, 64'(timeout_err), 64'h0);
  endtask

  // Runs one sweep: drives start, plays the responder, and derives the
  // expected results from the sweep rules.
  task automatic run_vec(input vec_t v, input string tag, input bit use_model);
    xfer_t       got[$];
    xfer_t       exp_q[$];
    logic [31:0] mem [int];
    xfer_t       cur;
    logic [31:0] resp, pat;
    int          cnt, d, bad, exp_err_v;
    int          busy_cyc, en_cyc, hb_low, viol, first_busy, first_en;
    int          exp_busy, exp_en, model_err;
    bit          active, en_prev, finished, timed_out;

    for (int s = 0; s < NUM_SLV; s++) begin
      for (int i = 0; i < v.nw; i++)
        exp_q.push_back('{2'(s), BASE + 32'(4 * i), 1'b1, PATTERN + 32'(s * 256) + 32'(i)});
      for (int i = 0; i < v.nw; i++)
        exp_q.push_back('{2'(s), BASE + 32'(4 * i), 1'b0, 32'h0});
    end

    busy_cyc = 0; en_cyc = 0; hb_low = 0; viol = 0; first_busy = -1; first_en = -1;
    exp_busy = 1; exp_en = 0; model_err = 0; cnt = 0; d = 0;
    active = 0; en_prev = 0; finished = 0; timed_out = 0;

    @(negedge hclk);
    start = 1'b1; num_words = 4'(v.nw);
    for (int cyc = 0; cyc < BUDGET && !finished; cyc++) begin
      @(negedge hclk);
      start     = v.restart && (cyc == 4);
      num_words = start ? 4'd7 : 4'($urandom);
      xfer_done = 1'b0;
      dout      = $urandom;
      if (done) begin
        finished = 1;
      end else begin
        if (busy) begin
          busy_cyc++;
          if (first_busy < 0) first_busy = cyc;
          if (!hbusreq_in) hb_low++;
        end
        if (enable) begin
          en_cyc++;
          if (first_en < 0) first_en = cyc;
          if (!hbusreq_in || !busy) viol++;
        end
        if (enable && !en_prev) begin
          cur = '{slv_sel_in, addr, wr, din};
          got.push_back(cur);
          d = (got.size() == 1) ? v.first_delay : v.delay;
          if (d == 0) d = $urandom_range(1, 5);
          if (d > TIMEOUT) begin
            timed_out = 1;
            exp_busy += TIMEOUT;
            exp_en   += TIMEOUT;
          end
          if (wr) mem[int'(slv_sel_in) * 4096 + int'(addr[11:0])] = din;
          cnt    = d;
          active = 1;
        end
        if (active && !enable) begin
          active = 0;  // transfer abandoned by an abort
        end else if (active) begin
          cnt--;
          if (cnt == 0) begin
            active    = 0;
            xfer_done = 1'b1;
            exp_busy += d + 1;
            exp_en   += d;
            if (!cur.wr) begin
              resp = mem.exists(int'(cur.sel) * 4096 + int'(cur.addr[11:0])) ?
                     mem[int'(cur.sel) * 4096 + int'(cur.addr[11:0])] : 32'hDEAD_BEEF;
              if (v.zero_mask[cur.sel])
                resp = 32'h0;
              else if (v.rnd_corrupt && $urandom_range(0, 3) == 0)
                resp = resp ^ (32'h1 << $urandom_range(0, 31));
              pat = PATTERN + (32'(cur.sel) << 8) + ((cur.addr - BASE) >> 2);
              if (resp != pat) model_err++;
              dout = resp;
            end
          end
        end else if (v.spurious && !enable && $urandom_range(0, 3) == 0) begin
          xfer_done = 1'b1;  // must be ignored outside WR/RD
        end
        en_prev = enable;
      end
    end
    start     = 1'b0;
    xfer_done = 1'b0;

    check({tag, "/done_seen"}, 64'(finished), 64'h1);
    check({tag, "/xfer_count"}, 64'(got.size()), 64'(v.exp_xfers));

    bad = -1;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (bad < 0 && (got[i].sel !== exp_q[i].sel || got[i].addr !== exp_q[i].addr ||
                      got[i].wr !== exp_q[i].wr || (exp_q[i].wr && got[i].din !== exp_q[i].din)))
        bad = i;
    n_cmp++;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL %s/xfer_list[%0d]: got sel=%0d addr=%h wr=%0b din=%h expected sel=%0d addr=%h wr=%0b din=%h",
               tag, bad, got[bad].sel, got[bad].addr, got[bad].wr, got[bad].din,
               exp_q[bad].sel, exp_q[bad].addr, exp_q[bad].wr, exp_q[bad].din);
    end

    exp_err_v = use_model ? model_err : v.exp_err;
    check({tag, "/err_cnt"}, 64'(err_cnt), 64'((exp_err_v > 255) ? 255 : exp_err_v));
    check({tag, "/err_cnt_sat"}, 64'(s_err_cnt), 64'((exp_err_v > 3) ? 3 : exp_err_v));
    check({tag, "/timeout_err"}, 64'(timeout_err), 64'(use_model ? timed_out : v.exp_tmo));
    check({tag, "/busy_cycles"}, 64'(busy_cyc), 64'(exp_busy));
    check({tag, "/enable_cycles"}, 64'(en_cyc), 64'(exp_en));
    check({tag, "/first_busy"}, 64'(first_busy), 64'(0));
    check({tag, "/first_enable"}, 64'(first_en), 64'((v.nw > 0) ? 0 : -1));
    check({tag, "/hbusreq_gaps"}, 64'(hb_low), 64'((v.nw > 0 && !timed_out) ? NUM_SLV : 1));
    check({tag, "/protocol_viol"}, 64'(viol), 64'(0));

    // One cycle later: done gone, bus idle, results held.
    @(negedge hclk);
    check({tag, "/done_width"}, 64'(done), 64'h0);
    check({tag, "/idle_outs"}, 64'({enable, hbusreq_in, busy, wr}), 64'h1);
    check({tag, "/err_hold"}, 64'(err_cnt), 64'((exp_err_v > 255) ? 255 : exp_err_v));
    check({tag, "/tmo_hold"}, 64'(timeout_err), 64'(use_model ? timed_out : v.exp_tmo));
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t rv;
    int   k, quiet;

    n_cmp = 0; n_bad = 0;
    hreset = 1'b1; start = 1'b0; num_words = '0; dout = '0; xfer_done = 1'b0;

    tbl[0] = '{2, 2, 2,    4'b0000, 1'b0, 1'b0, 1'b0, 16,  0, 1'b0}; // basic sweep
    tbl[1] = '{2, 2, 2,    4'b0100, 1'b0, 1'b0, 1'b0, 16,  2, 1'b0}; // slave 2 reads zero
    tbl[2] = '{0, 1, 1,    4'b0000, 1'b0, 1'b0, 1'b1, 0,   0, 1'b0}; // empty run
    tbl[3] = '{1, 1, 64,   4'b0000, 1'b0, 1'b0, 1'b0, 8,   0, 1'b0}; // done on expiry cycle wins
    tbl[4] = '{2, 2, 1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1,   0, 1'b1}; // first write never answered
    tbl[5] = '{2, 2, 2,    4'b0000, 1'b0, 1'b1, 1'b1, 16,  0, 1'b0}; // second start ignored
    tbl[6] = '{3, 1, 1,    4'b1010, 1'b0, 1'b0, 1'b0, 24,  6, 1'b0}; // two bad slaves
    tbl[7] = '{5, 1, 1,    4'b0001, 1'b0, 1'b0, 1'b1, 40,  5, 1'b0}; // 5 mismatches, sat at 3
    tbl[8] = '{1, 1, 65,   4'b0000, 1'b0, 1'b0, 1'b0, 1,   0, 1'b1}; // one past expiry
    tbl[9] = '{15, 1, 1,   4'b0000, 1'b0, 1'b0, 1'b0, 120, 0, 1'b0}; // maximum length

    repeat (3) @(negedge hclk);
    check_reset_vals("por");
    hreset = 1'b0;
    @(negedge hclk);

    for (int i = 0; i < 10; i++)
      run_vec(tbl[i], $sformatf("vec%0d", i), 1'b0);

    for (int i = 0; i < 8; i++) begin
      rv.nw          = $urandom_range(0, 6);
      rv.delay       = 0;
      rv.first_delay = 0;
      rv.zero_mask   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      rv.rnd_corrupt = 1'b1;
      rv.restart     = 1'($urandom);
      rv.spurious    = 1'b1;
      rv.exp_xfers   = 8 * rv.nw;
      rv.exp_err     = 0;
      rv.exp_tmo     = 1'b0;
      run_vec(rv, $sformatf("rnd%0d", i), 1'b1);
    end

    // Mid-run reset after one readback mismatch, with slave 1 writing.
    @(negedge hclk);
    start = 1'b1; num_words = 4'd1;
    @(negedge hclk);
    start = 1'b0;
    k = 0;
    while (!(enable && wr) && k < 20) begin @(negedge hclk); k++; end
    xfer_done = 1'b1;
    @(negedge hclk);
    xfer_done = 1'b0;
    k = 0;
    while (!(enable && !wr) && k < 20) begin @(negedge hclk); k++; end
    xfer_done = 1'b1; dout = 32'h0;
    @(negedge hclk);
    xfer_done = 1'b0;
    k = 0;
    while (!(enable && wr) && k < 20) begin @(negedge hclk); k++; end
    check("rst/pre_slave1_write", 64'({enable, wr, slv_sel_in}), 64'b1101);
    check("rst/pre_err_cnt", 64'(err_cnt), 64'h1);
    hreset = 1'b1;
    @(negedge hclk);
    check_reset_vals("rst_during");
    @(negedge hclk);
    @(negedge hclk);
    hreset = 1'b0;
    @(negedge hclk);
    check_reset_vals("rst_after");
    quiet = 0;
    repeat (10) begin
      @(negedge hclk);
      if (done || busy || enable) quiet++;
    end
    check("rst/no_activity", 64'(quiet), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_master_traffic_gen.md
Name: ahb_master_traffic_gen

Overview:
- Parametrised stimulus master that drives the AHB master interface's request side: addr, slv_sel_in, din, wr, enable, hbusreq_in.
- Replaces the fixed counter-scripted stimulus with a programmable write-then-readback sweep across NUM_SLV slaves.
- Self-checks read data, counts mismatches and aborts on a per-transfer timeout.
- Sits between the test top and the master interface.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; multiple of 8.
- NUM_SLV, 4, slaves swept per run; slv_sel_in width SEL_W = clog2(NUM_SLV), min 1.
- LEN_W, 4, width of num_words; max words per slave = 2^LEN_W-1.
- BASE_ADDR, 0, first address in every slave.
- PATTERN, 32'hA5A5_0000, data seed.
- TIMEOUT, 64, max cycles waiting for xfer_done per transfer.
- ERR_W, 8, error counter width.

Ports:
- hclk  in  1  clock.
- hreset  in  1  synchronous reset, active-high.
- start  in  1  one-cycle run request; honoured only when idle.
- num_words  in  LEN_W  words per slave; sampled on accepted start.
- dout  in  DATA_W  read data from master interface; valid with xfer_done during reads.
- xfer_done  in  1  one-cycle pulse: current transfer completed.
- addr  out  ADDR_W  transfer address.
- slv_sel_in  out  SEL_W  slave select.
- din  out  DATA_W  write data.
- wr  out  1  1 = write, 0 = read.
- enable  out  1  enable to master interface.
- hbusreq_in  out  1  bus request.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run (normal or abort).
- err_cnt  out  ERR_W  readback mismatches in last run, saturating.
- timeout_err  out  1  sticky: last run aborted on timeout.

Behaviour:
- Single clock hclk. Synchronous active-high reset hreset. All outputs registered.
- Reset values: addr 0, slv_sel_in 0, din 0, wr 1, enable 0, hbusreq_in 0, busy 0, done 0, err_cnt 0, timeout_err 0. FSM goes to IDLE. Reset mid-run abandons the run; no done pulse.
- FSM states: IDLE, WR, WGAP, RD, RGAP, FIN.
- IDLE:
  - start=1 latches num_words; clears slv, idx, err_cnt, timeout_err; sets busy=1.
  - num_words=0: go to FIN (no transfers). Otherwise go to WR.
  - start while busy is ignored.
- WR: addr = BASE_ADDR + idx*(DATA_W/8), truncated to ADDR_W. din = PATTERN + (slv<<8) + idx, truncated to DATA_W. wr=1, enable=1, hbusreq_in=1, slv_sel_in=slv.
  - On xfer_done go to WGAP.
- WGAP: enable=0, hbusreq_in stays 1; lasts exactly 1 cycle.
  - idx<num_words-1: idx++, back to WR.
  - Else: idx=0, go to RD.
- RD: same addr formula, wr=0, enable=1, hbusreq_in=1.
  - On xfer_done, compare dout with the expected pattern. On mismatch, err_cnt++, saturating at 2^ERR_W-1. Go to RGAP.
- RGAP: enable=0.
  - idx<num_words-1: idx++, back to RD.
  - Else if slv<NUM_SLV-1: slv++, idx=0, hbusreq_in=0 for this cycle, go to WR.
  - Else go to FIN.
- FIN: enable=0, hbusreq_in=0, wr=1, busy=0, done=1 for one cycle, then IDLE.
- Timeout: a cycle counter resets on entry to WR/RD and increments each cycle there.
  - Counter reaching TIMEOUT without xfer_done: timeout_err=1, go to FIN.
  - xfer_done in the same cycle as expiry: xfer_done wins.
- Outside WR/RD, xfer_done and dout are ignored.
- First enable rises 1 cycle after accepted start. done rises 1 cycle after the last RGAP.
- err_cnt and timeout_err hold after the run until the next accepted start.

Test Plan:
- Reset held 3 cycles mid-run -> all outputs at reset values the cycle after; busy=0; no done pulse.
- start, num_words=2, NUM_SLV=4, xfer_done 2 cycles after each enable, dout echoes written data -> per slave writes at addr 0x0 and 0x4 (slave 1 din 0xA5A5_0100, 0xA5A5_0101), then reads. 16 transfers, done pulse, err_cnt=0.
- Same run with dout forced to 0 on slave 2 reads -> err_cnt=2, done asserted, timeout_err=0.
- xfer_done withheld on first write -> timeout_err=1 after 64 cycles in WR; done pulse; enable=0; no further transfers.
- start with num_words=0 -> no enable activity, busy high 1 cycle, done pulse 1 cycle after start.
- Second start pulse during a run -> ignored; run completes unchanged. ERR_W=2 with 5 mismatches -> err_cnt saturates at 3.
